mem_req_initiator: RTL



---
 rtl/mem_if_pkg.sv | 32 +++
 rtl/mem_req_decode.sv | 52 +++++
 rtl/mem_req_initiator.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the CPU-side data-memory interface: RV32I load/store
// funct3 codes, memory size masks, initiator FSM states and MMIO defaults.
package mem_if_pkg;

    // RV32I load/store funct3 codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Size masks presented to memory in sign_mask[2:0]
    localparam logic [2:0] SZ_B = 3'b001;
    localparam logic [2:0] SZ_H = 3'b011;
    localparam logic [2:0] SZ_W = 3'b111;

    // LED register; only a word store may target it
    localparam logic [31:0] MMIO_LED_ADDR_DEF = 32'h0000_2000;

    // Cycles to wait for clk_stall to rise after a strobe
    localparam int STALL_TIMEOUT_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

endpackage

// File: rtl/mem_req_decode.sv
// Combinational decode of a load/store request: funct3 and address give the
// memory sign/size mask plus misaligned and illegal flags. Also used by the
// hazard unit, so it carries no state.
module mem_req_decode
    import mem_if_pkg::*;
#(
    parameter logic [31:0] MMIO_LED_ADDR = MMIO_LED_ADDR_DEF
) (
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    output logic [3:0]  sign_mask,
    output logic        misaligned,
    output logic        illegal
);

    logic [2:0] size;

    // Decode size, alignment and legality; unsigned variants exist for loads only
    always_comb begin
        size       = 3'b000;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            F3_B:  size = SZ_B;
            F3_H: begin
                size       = SZ_H;
                misaligned = addr[0];
            end
            F3_W: begin
                size       = SZ_W;
                misaligned = (addr[1:0] != 2'b00);
            end
            F3_BU: begin
                size    = SZ_B;
                illegal = is_store;
            end
            F3_HU: begin
                size       = SZ_H;
                misaligned = addr[0];
                illegal    = is_store;
            end
            default: illegal = 1'b1;
        endcase
        // The LED register only takes full-word writes
        if (is_store && (addr == MMIO_LED_ADDR) && (funct3 != F3_W)) begin
            illegal = 1'b1;
        end
        sign_mask = {~is_store & ~funct3[2], size};
    end

endmodule

// File: rtl/mem_req_initiator.sv
// Load/store initiator: accepts one request from the MEM stage, drives the
// data-memory strobes and runs the clk_stall handshake, then returns a
// one-cycle completion (or error) pulse with the load result.
//
// Request handshake: a request transfers on a rising clk edge where
// req_valid & req_ready are both high. req_ready depends only on the FSM state
// and clk_stall, never on req_valid, so the requester may hold req_valid and
// its payload until it sees the transfer. Completion is a single-cycle
// rsp_valid pulse with no back-pressure; rsp_err is meaningful only with it.
module mem_req_initiator
    import mem_if_pkg::*;
#(
    parameter int          STALL_TIMEOUT = STALL_TIMEOUT_DEF,
    parameter logic [31:0] MMIO_LED_ADDR = MMIO_LED_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] addr,
    output logic [31:0] write_data,
    output logic        memread,
    output logic        memwrite,
    output logic [3:0]  sign_mask,
    input  logic [31:0] read_data,
    input  logic        clk_stall
);

    localparam int CNT_W = $clog2(STALL_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             lat_store;

    logic [3:0] dec_mask;
    logic       dec_misaligned;
    logic       dec_illegal;

    mem_req_decode #(
        .MMIO_LED_ADDR (MMIO_LED_ADDR)
    ) u_decode (
        .is_store   (req_is_store),
        .funct3     (req_funct3),
        .addr       (req_addr),
        .sign_mask  (dec_mask),
        .misaligned (dec_misaligned),
        .illegal    (dec_illegal)
    );

    // A memory still busy from before a reset blocks new requests too
    assign req_ready = (state == ST_IDLE) & ~clk_stall;

    // Initiator FSM; every output is registered and rsp_* pulse for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            lat_store  <= 1'b0;
            memread    <= 1'b0;
            memwrite   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'h0;
            addr       <= 32'h0;
            write_data <= 32'h0;
            sign_mask  <= 4'h0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_store <= req_is_store;
                        if (dec_illegal || dec_misaligned) begin
                            // Rejected locally: memory never sees a strobe
                            state     <= ST_ERR;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            addr       <= req_addr;
                            write_data <= req_wdata;
                            sign_mask  <= dec_mask;
                            memread    <= ~req_is_store;
                            memwrite   <= req_is_store;
                            state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    memread  <= 1'b0;
                    memwrite <= 1'b0;
                    wait_cnt <= '0;
                    state    <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (clk_stall) begin
                        state <= ST_WAIT_LO;
                    end else if (wait_cnt == CNT_LAST) begin
                        state     <= ST_ERR;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_WAIT_LO: begin
                    if (!clk_stall) begin
                        if (!lat_store) begin
                            rsp_rdata <= read_data;
                        end
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                ST_ERR:   state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule
